// File: rtl/scroll_msg_gen.sv
// Scrolling message source for an 8-digit seven-segment multiplexer: buffer, window stepper, glyph decode.
// Optional SCROLL_BLINK_EN: flash all digits (blank/glyph) while pausing after a wrap.
module scroll_msg_gen #(
   parameter int unsigned MSG_LEN     = 16,
   parameter int unsigned TICK_DIV    = 25000000,
   parameter int unsigned PAUSE_STEPS = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
   input  logic [4:0]                   wr_data,
   input  logic [$clog2(MSG_LEN):0]     len,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         dir,
   output logic                         busy,
   output logic                         wrap_pulse,
   output logic [6:0]                   in7,
   output logic [6:0]                   in6,
   output logic [6:0]                   in5,
   output logic [6:0]                   in4,
   output logic [6:0]                   in3,
   output logic [6:0]                   in2,
   output logic [6:0]                   in1,
   output logic [6:0]                   in0
);

   localparam int unsigned AW     = $clog2(MSG_LEN);
   localparam int unsigned LW     = AW + 1;
   localparam int unsigned PW     = $clog2(MSG_LEN + 8 + 1);
   localparam int unsigned SW     = PW + 1;
   localparam int unsigned TW     = $clog2(TICK_DIV);
   localparam int unsigned CW     = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
   localparam int unsigned DIGITS = 8;
   localparam bit          PAUSE_EN = (PAUSE_STEPS > 0);
`ifdef SCROLL_BLINK_EN
   localparam bit          BLINK_EN = 1'b1;
`else
   localparam bit          BLINK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]   presc_q, presc_d;
   logic [CW-1:0]   pcnt_q, pcnt_d;
   logic [LW-1:0]   len_q, len_d;
   logic            wrap_q, wrap_d;
   logic            busy_q, busy_d;
   logic            blink_q, blink_d;
   logic [4:0]      mem_q [MSG_LEN];
   logic [6:0]      seg_q [DIGITS];
   logic [6:0]      seg_d [DIGITS];

   logic [LW-1:0]   len_clamp;
   logic [PW-1:0]   v_len;
   logic            tick;

   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'h00: g = 7'h40;  5'h01: g = 7'h79;  5'h02: g = 7'h24;  5'h03: g = 7'h30;
         5'h04: g = 7'h19;  5'h05: g = 7'h12;  5'h06: g = 7'h02;  5'h07: g = 7'h78;
         5'h08: g = 7'h00;  5'h09: g = 7'h10;  5'h0A: g = 7'h08;  5'h0B: g = 7'h03;
         5'h0C: g = 7'h46;  5'h0D: g = 7'h21;  5'h0E: g = 7'h06;  5'h0F: g = 7'h0E;
         5'h11: g = 7'h3F;  5'h12: g = 7'h09;  5'h13: g = 7'h47;  5'h14: g = 7'h0C;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   assign len_clamp = (len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : len;
   assign v_len     = PW'(len_q) + PW'(8);
   assign tick      = (presc_q == TW'(TICK_DIV - 1));

   // Message buffer; resets to all blanks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < MSG_LEN; k++) mem_q[k] <= 5'h10;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Control: stop has priority, then (re)start, then normal stepping
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      len_d   = len_q;
      wrap_d  = 1'b0;
      blink_d = blink_q;
      if (stop) begin
         state_d = ST_IDLE;
         blink_d = 1'b0;
      end else if (start && (len_clamp != '0)) begin
         state_d = ST_RUN;
         ptr_d   = '0;
         presc_d = '0;
         pcnt_d  = '0;
         len_d   = len_clamp;
         blink_d = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (tick) begin
                  presc_d = '0;
                  if (!dir) begin
                     if (ptr_q == PW'(v_len - PW'(1))) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                     end else begin
                        ptr_d = PW'(ptr_q + PW'(1));
                     end
                  end else begin
                     if (ptr_q == '0) begin
                        ptr_d  = PW'(v_len - PW'(1));
                        wrap_d = 1'b1;
                     end else begin
                        ptr_d = PW'(ptr_q - PW'(1));
                     end
                  end
                  if (wrap_d && PAUSE_EN) begin
                     state_d = ST_PAUSE;
                     pcnt_d  = '0;
                     blink_d = 1'b1;
                  end
               end else begin
                  presc_d = TW'(presc_q + TW'(1));
               end
            end
            ST_PAUSE: begin
               if (tick) begin
                  presc_d = '0;
                  blink_d = ~blink_q;
                  if (pcnt_q == CW'(PAUSE_STEPS - 1)) begin
                     state_d = ST_RUN;
                     pcnt_d  = '0;
                     blink_d = 1'b0;
                  end else begin
                     pcnt_d = CW'(pcnt_q + CW'(1));
                  end
               end else begin
                  presc_d = TW'(presc_q + TW'(1));
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Window decode: digit i shows stream position (ptr + i) mod V, blank beyond L
   always_comb begin
      logic [SW-1:0] sum;
      logic [PW-1:0] pos;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         sum = SW'(ptr_q) + SW'(i);
         if (sum >= SW'(v_len)) sum = SW'(sum - SW'(v_len));
         pos = PW'(sum);
         if (BLINK_EN && blink_q)          seg_d[i] = 7'h7F;
         else if (pos < PW'(len_q))        seg_d[i] = glyph(mem_q[AW'(pos)]);
         else                              seg_d[i] = 7'h7F;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         len_q   <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         blink_q <= 1'b0;
         for (int unsigned i = 0; i < DIGITS; i++) seg_q[i] <= 7'h7F;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         len_q   <= len_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
         blink_q <= blink_d;
         for (int unsigned i = 0; i < DIGITS; i++) seg_q[i] <= seg_d[i];
      end
   end

   assign busy       = busy_q;
   assign wrap_pulse = wrap_q;
   assign in7 = seg_q[0];
   assign in6 = seg_q[1];
   assign in5 = seg_q[2];
   assign in4 = seg_q[3];
   assign in3 = seg_q[4];
   assign in2 = seg_q[5];
   assign in1 = seg_q[6];
   assign in0 = seg_q[7];

endmodule

// File: tb/tb_scroll_msg_gen.sv
// Directed bench for scroll_msg_gen with MSG_LEN=16, TICK_DIV=4, PAUSE_STEPS=2.
module tb_scroll_msg_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [4:0] wr_data;
   logic [4:0] len;
   logic       start, stop, dir;
   logic       busy, wrap_pulse;
   logic [6:0] in7, in6, in5, in4, in3, in2, in1, in0;
   logic [55:0] segs;

   int errors = 0;
   int checks = 0;

   logic [55:0] blank8, w0, w1, wr_right;

   scroll_msg_gen #(.MSG_LEN(16), .TICK_DIV(4), .PAUSE_STEPS(2)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .start(start), .stop(stop), .dir(dir), .busy(busy), .wrap_pulse(wrap_pulse),
      .in7(in7), .in6(in6), .in5(in5), .in4(in4), .in3(in3), .in2(in2), .in1(in1), .in0(in0)
   );

   always #5 clk = ~clk;
   assign segs = {in7, in6, in5, in4, in3, in2, in1, in0};

   function automatic logic [55:0] p8(input logic [6:0] a, b, c, d, e, f, g, h);
      return {a, b, c, d, e, f, g, h};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; len = 0;
      start = 0; stop = 0; dir = 0;
      step(2);
      checks++; if (segs !== blank8) begin errors++; $display("FAIL reset_segs got=%h exp=%h", segs, blank8); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_pulse); end
      reset_n = 1'b1;
      step(3);
      checks++; if (segs !== blank8) begin errors++; $display("FAIL reset_release_segs got=%h exp=%h", segs, blank8); end
   endtask

   task automatic load_digits;
      for (int a = 0; a < 8; a++) begin
         wr_en = 1; wr_addr = 4'(a); wr_data = 5'(a);
         step(1);
      end
      wr_en = 0;
      step(1);
   endtask

   task automatic test_scroll_left;
      len = 5'd8; dir = 0; start = 1;
      step(1);
      start = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL left_busy got=%b exp=1", busy); end
      step(1);
      checks++; if (segs !== w0) begin errors++; $display("FAIL left_window0 got=%h exp=%h", segs, w0); end
      step(3);
      checks++; if (segs !== w0) begin errors++; $display("FAIL left_hold got=%h exp=%h", segs, w0); end
      step(1);
      checks++; if (segs !== w1) begin errors++; $display("FAIL left_window1 got=%h exp=%h", segs, w1); end
   endtask

   task automatic test_wrap_pause;
      logic [55:0] snap [81];
      logic        bsnap [81];
      int          cnt, at;
      cnt = 0; at = -1;
      dir = 0; start = 1;
      step(1);
      start = 0;
      for (int n = 1; n <= 80; n++) begin
         step(1);
         snap[n] = segs; bsnap[n] = busy;
         if (wrap_pulse === 1'b1) begin cnt++; at = n; end
      end
      checks++; if (cnt != 1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", cnt); end
      checks++; if (at != 64) begin errors++; $display("FAIL wrap_cycle got=%0d exp=64", at); end
      checks++; if (snap[65] !== w0) begin errors++; $display("FAIL pause_start got=%h exp=%h", snap[65], w0); end
      checks++; if (snap[76] !== w0) begin errors++; $display("FAIL pause_hold got=%h exp=%h", snap[76], w0); end
      checks++; if (snap[77] !== w1) begin errors++; $display("FAIL pause_resume got=%h exp=%h", snap[77], w1); end
      checks++; if (bsnap[70] !== 1'b1) begin errors++; $display("FAIL pause_busy got=%b exp=1", bsnap[70]); end
   endtask

   task automatic test_dir_right;
      dir = 1; start = 1;
      step(1);
      start = 0;
      step(4);
      checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL right_wrap got=%b exp=1", wrap_pulse); end
      step(1);
      checks++; if (segs !== wr_right) begin errors++; $display("FAIL right_window got=%h exp=%h", segs, wr_right); end
      checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL right_wrap_once got=%b exp=0", wrap_pulse); end
   endtask

   task automatic test_start_stop;
      stop = 1;
      step(1);
      stop = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_pause_busy got=%b exp=0", busy); end
      start = 1; stop = 1;
      step(1);
      start = 0; stop = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got=%b exp=0", busy); end
      step(2);
      checks++; if (segs !== wr_right) begin errors++; $display("FAIL start_stop_hold got=%h exp=%h", segs, wr_right); end
      dir = 0; start = 1;
      step(1);
      start = 0;
      step(5);
      checks++; if (segs !== w1) begin errors++; $display("FAIL run_before_stop got=%h exp=%h", segs, w1); end
      stop = 1;
      step(1);
      stop = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_run_busy got=%b exp=0", busy); end
      step(20);
      checks++; if (segs !== w1) begin errors++; $display("FAIL stop_frozen got=%h exp=%h", segs, w1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_frozen_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      dir = 1; len = 5'd8; start = 1;
      step(1);
      start = 0;
      step(4);
      checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL mid_prewrap got=%b exp=1", wrap_pulse); end
      reset_n = 1'b0;
      #1;
      checks++; if (segs !== blank8) begin errors++; $display("FAIL mid_reset_segs got=%h exp=%h", segs, blank8); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
      checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL mid_reset_wrap got=%b exp=0", wrap_pulse); end
      step(1);
      reset_n = 1'b1;
      step(3);
      checks++; if (segs !== blank8) begin errors++; $display("FAIL mid_release_segs got=%h exp=%h", segs, blank8); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_len_zero;
      dir = 0; len = 5'd0; start = 1;
      step(1);
      start = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got=%b exp=0", busy); end
      step(2);
      checks++; if (segs !== blank8) begin errors++; $display("FAIL len0_segs got=%h exp=%h", segs, blank8); end
      wr_en = 1; wr_addr = 4'd0; wr_data = 5'h12;
      step(1);
      wr_en = 0;
      step(2);
      checks++; if (segs !== blank8) begin errors++; $display("FAIL len0_write got=%h exp=%h", segs, blank8); end
   endtask

   task automatic test_idle_write;
      logic [55:0] e1, e2;
      e1 = p8(7'h09, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      e2 = p8(7'h09, 7'h47, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      len = 5'd8; start = 1;
      step(1);
      start = 0; stop = 1;
      step(1);
      stop = 0;
      step(1);
      checks++; if (segs !== e1) begin errors++; $display("FAIL idle_view got=%h exp=%h", segs, e1); end
      wr_en = 1; wr_addr = 4'd1; wr_data = 5'h13;
      step(1);
      wr_en = 0;
      checks++; if (segs !== e1) begin errors++; $display("FAIL idle_write_latency got=%h exp=%h", segs, e1); end
      step(1);
      checks++; if (segs !== e2) begin errors++; $display("FAIL idle_write_visible got=%h exp=%h", segs, e2); end
   endtask

   initial begin
      blank8   = p8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      w0       = p8(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78);
      w1       = p8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h7F);
      wr_right = p8(7'h7F, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
      test_reset;
      load_digits;
      test_scroll_left;
      test_wrap_pause;
      test_dir_right;
      test_start_stop;
      test_reset_mid;
      test_len_zero;
      test_idle_write;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
